bus_master_bridge: RTL and testbench

//  Byte-stream-to-bus initiator: parses framed commands from a byte source (UART receiver)
//  and issues single read/write transactions on the peripheral/RAM bus (addr/data/ctrl),

---
 rtl/bus_master_bridge.sv | 127 ++++++++++++
 tb/tb_bus_master_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bus_master_bridge.sv
// bus_master_bridge: byte-framed host commands turned into single bus reads/writes with byte responses
module bus_master_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_HOLD = 2,
  parameter int GAP_TO  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              ctrl,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, AH, AL, DH, DL, REQ, ACCESS, RESP} state_t;
  localparam int CNT_MAX = (RD_WAIT > WR_HOLD + 1) ? RD_WAIT : WR_HOLD + 1;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int GW = $clog2(GAP_TO + 1);
  localparam logic [CW-1:0] WR_END = CW'(WR_HOLD);
  localparam logic [CW-1:0] WR_REL = CW'(WR_HOLD + 1);
  localparam logic [CW-1:0] RD_SMP = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] RD_REL = CW'(RD_WAIT);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TO - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] d_reg;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap;
  logic [7:0] b0, b1, q0, q1;
  logic wr, two, idx, ovr, q_en, q_two;
  logic frame, timeout, rel, acc_drive, wr_drive, smp;
  assign frame     = state inside {AH, AL, DH, DL};
  assign timeout   = frame && !rx_valid && gap == GAP_LAST;
  assign rel       = state == ACCESS && cnt == (wr ? WR_REL : RD_REL);
  assign acc_drive = state == ACCESS && !rel && bus_gnt;
  assign wr_drive  = acc_drive && wr && cnt < WR_END;
  assign smp       = acc_drive && !wr && cnt == RD_SMP;
  assign bus_req   = state == REQ || (state == ACCESS && !rel);
  assign addr      = acc_drive ? a_reg : '0;
  assign ctrl      = wr_drive;
  assign data      = wr_drive ? d_reg : 'z;
  assign tx_valid  = state == RESP;
  assign tx_data   = state == RESP ? (idx ? b1 : b0) : 8'h00;
  assign busy      = state != IDLE;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state and response queueing; a frame timeout overrides everything
  always_comb begin
    state_n = state;
    q_en = 1'b0;
    q0 = 8'h15;
    q1 = 8'h15;
    q_two = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == 8'h57 || rx_data == 8'h52) state_n = AH;
        else begin
          q_en = 1'b1;
          state_n = RESP;
        end
      end
      AH: state_n = rx_valid ? AL : AH;
      AL: state_n = rx_valid ? (wr ? DH : REQ) : AL;
      DH: state_n = rx_valid ? DL : DH;
      DL: state_n = rx_valid ? REQ : DL;
      REQ: state_n = bus_gnt ? ACCESS : REQ;
      ACCESS: if (rel) begin
        q_en = 1'b1;
        state_n = RESP;
        q0 = wr ? 8'h06 : d_reg[15:8];
        q1 = d_reg[7:0];
        q_two = !wr;
      end else if (!bus_gnt) begin
        q_en = 1'b1;
        state_n = RESP;
      end
      RESP: state_n = (tx_ready && idx == two) ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      q_en = 1'b1;
      q0 = 8'h15;
      q_two = 1'b0;
      state_n = RESP;
    end
  end
  // frame capture, access timing, read sampling, response bytes and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= 1'b0;
      a_reg <= '0;
      d_reg <= '0;
      cnt <= '0;
      gap <= '0;
      b0 <= 8'h00;
      b1 <= 8'h00;
      two <= 1'b0;
      idx <= 1'b0;
      ovr <= 1'b0;
    end else begin
      gap <= (frame && !rx_valid) ? gap + 1'b1 : '0;
      cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
      if (rx_valid && state == IDLE) wr <= rx_data == 8'h57;
      if (rx_valid && (state == AH || state == AL)) a_reg <= {a_reg[ADDR_W-9:0], rx_data};
      if (rx_valid && (state == DH || state == DL)) d_reg <= {d_reg[DATA_W-9:0], rx_data};
      if (smp) d_reg <= data;
      if (q_en) begin
        b0 <= (ovr && !q_two) ? 8'h15 : q0;
        b1 <= ovr ? 8'h15 : q1;
        two <= q_two;
      end
      idx <= q_en ? 1'b0 : (state == RESP && tx_ready) ? 1'b1 : idx;
      ovr <= (ovr && !q_en) || (rx_valid && state inside {REQ, ACCESS, RESP});
    end
  end
endmodule

// File: tb/tb_bus_master_bridge.sv
// tb_bus_master_bridge: directed plus randomized frames checked against a memory/response model
module tb_bus_master_bridge;
  localparam int RD_WAIT = 2;
  localparam int WR_HOLD = 2;
  localparam int GAP_TO  = 100;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, tx_valid, tx_ready = 0, bus_req, bus_gnt = 0, ctrl, busy;
  logic [15:0] addr;
  wire  [15:0] data;
  logic [15:0] bmem [0:65535];
  logic [15:0] mdl [logic [15:0]];
  bit ovr_m = 0;
  int tests = 0, fails = 0;

  // CPU-side memory answers reads whenever the bridge owns the bus and is not writing
  assign data = (bus_req && bus_gnt && !ctrl) ? bmem[addr] : 'z;
  always #5 clk = ~clk;

  bus_master_bridge #(.ADDR_W(16), .DATA_W(16), .RD_WAIT(RD_WAIT), .WR_HOLD(WR_HOLD), .GAP_TO(GAP_TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .addr(addr), .data(data), .ctrl(ctrl), .busy(busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    tick;
    rx_valid = 0;
  endtask

  function automatic logic [15:0] mread(input logic [15:0] a);
    return mdl.exists(a) ? mdl[a] : (a ^ 16'h5A5A);
  endfunction

  task automatic recv(input logic [7:0] exp, input int rdly, input bit inj);
    int k = 0;
    while (!tx_valid && k < 100) begin tick; k++; end
    chk("tx_valid", {31'd0, tx_valid}, 1);
    chk("tx_data", {24'd0, tx_data}, {24'd0, exp});
    for (int i = 0; i < rdly; i++) begin
      if (inj && i == 0) begin send_byte(8'hEE); ovr_m = 1; end
      else tick;
      chk("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp});
    end
    tx_ready = 1;
    tick;
    tx_ready = 0;
  endtask

  task automatic expect_resp(input logic [7:0] e0, input logic [7:0] e1, input bit two, input int rdly, input bit inj);
    logic [7:0] x0 = e0, x1 = e1;
    if (ovr_m) begin
      if (two) x1 = 8'h15; else x0 = 8'h15;
      ovr_m = 0;
    end
    recv(x0, rdly, inj);
    if (two) recv(x1, rdly, 0);
  endtask

  task automatic xact(input bit w, input logic [15:0] a, input logic [15:0] d, input int gdly, input int rdly, input bit inj, input int drop_at);
    int k = 0, cc = 0;
    bit low = 0;
    logic [15:0] rv;
    send_byte(w ? 8'h57 : 8'h52);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    if (w) begin send_byte(d[15:8]); send_byte(d[7:0]); end
    chk("req_lat", {31'd0, bus_req}, 1);
    chk("busy", {31'd0, busy}, 1);
    for (int i = 0; i < gdly; i++) begin
      chk("pre_gnt", {15'd0, addr, ctrl}, 0);
      tick;
    end
    rv = mread(a);
    bus_gnt = 1;
    while (!tx_valid && k < 40) begin
      tick;
      k++;
      if (ctrl) begin
        cc++;
        chk("wr_addr", {16'd0, addr}, {16'd0, a});
        chk("wr_data", {16'd0, data}, {16'd0, d});
        bmem[addr] = data;
      end
      if (addr != 0 || ctrl) chk("owned", {31'd0, bus_req && bus_gnt}, 1);
      if (!bus_req) begin low = 1; bus_gnt = 0; end
      if (k == drop_at) bus_gnt = 0;
    end
    bus_gnt = 0;
    if (drop_at > 0) expect_resp(8'h15, 8'h00, 0, rdly, inj);
    else if (w) begin
      chk("ack_lat", k, WR_HOLD + 3);
      chk("wr_cycles", cc, WR_HOLD);
      mdl[a] = d;
      expect_resp(8'h06, 8'h00, 0, rdly, inj);
    end else begin
      chk("rd_req_low", {31'd0, low}, 1);
      expect_resp(rv[15:8], rv[7:0], 1, rdly, inj);
    end
  endtask

  initial begin
    int k;
    bit seen;
    bit w, inj;
    for (int i = 0; i < 65536; i++) bmem[i] = 16'(i) ^ 16'h5A5A;
    repeat (3) tick;
    chk("rst_tx", {23'd0, tx_valid, tx_data}, 0);
    chk("rst_bus", {14'd0, bus_req, addr, ctrl}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 0;
    tick;
    xact(1, 16'h0012, 16'hABCD, 4, 0, 0, 0);
    bmem[16'hFF10] = 16'h0003;
    mdl[16'hFF10] = 16'h0003;
    xact(0, 16'hFF10, 16'h0000, 2, 20, 1, 0);
    xact(1, 16'h0020, 16'h1357, 1, 1, 0, 0);
    send_byte(8'h41);
    chk("nak_noreq", {31'd0, bus_req}, 0);
    expect_resp(8'h15, 8'h00, 0, 0, 0);
    chk("nak_idle", {31'd0, busy}, 0);
    xact(0, 16'h0012, 16'h0000, 0, 0, 0, 0);
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h12);
    k = 0;
    seen = 0;
    while (!tx_valid && k < GAP_TO + 20) begin
      tick;
      k++;
      if (bus_req) seen = 1;
    end
    chk("gap_lat", {31'd0, k >= GAP_TO - 1 && k <= GAP_TO + 1}, 1);
    chk("gap_noreq", {31'd0, seen}, 0);
    expect_resp(8'h15, 8'h00, 0, 0, 0);
    xact(0, 16'h0030, 16'h0000, 0, 0, 0, 1);
    for (int n = 0; n < 24; n++) begin
      w = $urandom_range(0, 1) == 1;
      inj = $urandom_range(0, 3) == 0;
      xact(w, 16'h0010 + 16'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 5),
           $urandom_range(1, 3), inj, 0);
    end
    send_byte(8'h57);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h12);
    send_byte(8'h34);
    bus_gnt = 1;
    k = 0;
    while (!ctrl && k < 20) begin tick; k++; end
    chk("rst_setup", {31'd0, ctrl}, 1);
    rst = 1;
    tick;
    chk("midrst_ctrl", {31'd0, ctrl}, 0);
    chk("midrst_req", {31'd0, bus_req}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_addr", {16'd0, addr}, 0);
    bus_gnt = 0;
    tick;
    tick;
    rst = 0;
    ovr_m = 0;
    tick;
    xact(0, 16'h0012, 16'h0000, 1, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
